// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the inter-stage pipeline register.
package pipe_stage_reg_pkg;

  localparam logic RstActive = 1'b0;

  localparam logic [4:0]  NopRegAddr   = 5'd0;
  localparam logic [31:0] ZeroWord     = 32'd0;
  localparam logic [63:0] ZeroDword    = 64'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // Stall vector bit positions, one per pipeline stage.
  localparam int unsigned StallWDefault = 6;
  localparam int unsigned StagePc  = 0;
  localparam int unsigned StageIf  = 1;
  localparam int unsigned StageId  = 2;
  localparam int unsigned StageEx  = 3;
  localparam int unsigned StageMem = 4;
  localparam int unsigned StageWb  = 5;

  typedef enum logic [1:0] {
    OpAdvance,
    OpFlush,
    OpBubble,
    OpHold
  } stage_op_e;

  function automatic stage_op_e decode_op(logic flush, logic s_here, logic s_next);
    if (flush) return OpFlush;
    if (s_here && s_next) return OpHold;
    if (s_here) return OpBubble;
    return OpAdvance;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying the GPR and HI/LO write-back bundles,
// with flush, bubble/hold handling and saturating statistics.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned HILO_W     = 32,
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned STAGE      = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HOLD_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  clr_stats,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [HILO_W-1:0]     in_hi,
  input  logic [HILO_W-1:0]     in_lo,
  input  logic                  in_whilo,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [HILO_W-1:0]     out_hi,
  output logic [HILO_W-1:0]     out_lo,
  output logic                  out_whilo,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  hold_timeout,
  output logic                  protocol_err
);

  localparam int unsigned HoldW = $clog2(HOLD_LIMIT + 1);
  localparam logic [HoldW-1:0] HoldLimit = HoldW'(HOLD_LIMIT);

  logic      s_here, s_next;
  stage_op_e op;
  logic      unused_stall;

  assign s_here       = stall[STAGE];
  assign s_next       = stall[STAGE+1];
  assign unused_stall = ^stall;
  assign op           = decode_op(flush, s_here, s_next);

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      out_valid <= 1'b0;
      out_wd    <= '0;
      out_wreg  <= WriteDisable;
      out_wdata <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_whilo <= WriteDisable;
    end else begin
      unique case (op)
        OpFlush, OpBubble: begin
          out_valid <= 1'b0;
          out_wd    <= '0;
          out_wreg  <= WriteDisable;
          out_wdata <= '0;
          out_hi    <= '0;
          out_lo    <= '0;
          out_whilo <= WriteDisable;
        end
        OpHold: begin
        end
        default: begin
          // An invalid entry may carry stale data but must never write.
          out_valid <= in_valid;
          out_wd    <= in_wd;
          out_wreg  <= in_wreg & in_valid;
          out_wdata <= in_wdata;
          out_hi    <= in_hi;
          out_lo    <= in_lo;
          out_whilo <= in_whilo & in_valid;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk(clk),
    .rst(rst),
    .inc(op == OpBubble),
    .clr(clr_stats),
    .q  (bubble_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(op == OpFlush),
    .clr(clr_stats),
    .q  (flush_cnt)
  );

  logic             is_hold;
  logic [HoldW-1:0] hold_run;
  logic             hold_inc, hold_clr;

  assign is_hold  = (op == OpHold);
  assign hold_inc = is_hold && (hold_run != HoldLimit);
  assign hold_clr = clr_stats || !is_hold;

  sat_counter #(
    .W(HoldW)
  ) u_hold_run (
    .clk(clk),
    .rst(rst),
    .inc(hold_inc),
    .clr(hold_clr),
    .q  (hold_run)
  );

  logic hold_timeout_d, hold_timeout_q;
  logic protocol_err_d, protocol_err_q;

  always_comb begin
    hold_timeout_d = hold_timeout_q;
    protocol_err_d = protocol_err_q;
    if (clr_stats) begin
      hold_timeout_d = 1'b0;
      protocol_err_d = 1'b0;
    end else begin
      // Flag on the same edge the run counter reaches the limit.
      if (is_hold && (hold_run >= HoldLimit - HoldW'(1))) hold_timeout_d = 1'b1;
      if (!s_here && s_next) protocol_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      hold_timeout_q <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      hold_timeout_q <= hold_timeout_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign hold_timeout = hold_timeout_q;
  assign protocol_err = protocol_err_q;

endmodule
